pc_pipeline: RTL and testbench
==============================

Name: pc_pipeline

Overview:
- Parametrised PC generator and PC-tracking shift register for the Riscv151 core.
- Produces the next fetch address for the synchronous-read icache.
- Carries each in-flight instruction's PC and a valid bit through DEPTH stages.
- Handles a global memory stall, and a control-flow redirect with squash of younger stages. A redirect that arrives during a stall is held and applied when the stall ends.

Parameters:
- XLEN, 32, address width.
- DEPTH, 4, number of tracked PC stages; stage 0 = instruction currently on icache_dout; minimum 2.
- RESET_PC, 32'h0000_2000, first fetched address after reset.
- INCR, 4, sequential PC increment.
- REDIRECT_STAGE, 2, stage index whose instruction raises redirect; range 0..DEPTH-2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  global memory stall; freezes all state when 1.
- redirect_valid  in  1  branch/jump taken by the instruction in stage REDIRECT_STAGE.
- redirect_target  in  XLEN  redirect address; bits [1:0] ignored and treated as 0.
- next_pc  out  XLEN  combinational fetch address, drives icache_addr.
- icache_re  out  1  fetch enable.
- stage_pc  out  DEPTH*XLEN  packed stage PCs; stage i occupies bits [i*XLEN +: XLEN].
- stage_valid  out  DEPTH  per-stage valid bit.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - stage_pc[0] = RESET_PC-INCR; all other stage_pc = 0.
  - stage_valid = 0; pending_valid = 0; pending_target = 0.
  - icache_re = 0 while reset is high, 1 otherwise.
- next_pc, combinational, first match wins:
  1. redirect_valid: {redirect_target[XLEN-1:2], 2'b00}.
  2. pending_valid: pending_target.
  3. Otherwise: stage_pc[0] + INCR, wrapping modulo 2^XLEN.
- First cycle after reset deasserts: next_pc = RESET_PC. One edge later: stage 0 holds RESET_PC, valid = 1.
- Advance cycle (stall=0), at the edge:
  - stage_pc[0] <= next_pc; stage_valid[0] <= 1.
  - For i = 1..DEPTH-1: stage_pc[i] <= stage_pc[i-1]; stage_valid[i] <= stage_valid[i-1].
  - pending_valid <= 0.
- Squash: when an advance applies a redirect (live or pending), stage_valid[i] <= 0 for i = 1..REDIRECT_STAGE. These slots receive the wrong-path younger instructions. The new stage 0 is valid. The redirecting instruction moves to stage REDIRECT_STAGE+1 and stays valid.
- Stall cycle (stall=1):
  - All stage registers hold.
  - If redirect_valid: pending_valid <= 1 and pending_target <= masked target. A later redirect during the same stall overwrites it (last one wins).
  - next_pc still follows the priority above, so the icache sees the pending target while stalled.
- Stall and redirect in the same cycle: the redirect is captured as pending, nothing advances, and the squash is applied at the first advance edge.
- Live redirect with pending_valid=1 on an advance: the live target wins, pending is cleared, and one squash is applied.
- PC wrap: 32'hFFFF_FFFC + 4 = 0, with no flag.
- Reset asserted mid-stall or with pending set: all state, including pending, is cleared immediately.
- Latency: fetch address to stage 0 is one advance edge; stage i to stage i+1 is one advance edge.
- No combinational path from stall to next_pc.

Test Plan:
- Reset release, stall=0, no redirect → next_pc = 0x2000, 0x2004, 0x2008…; after 4 edges stage_pc = {0x200C, 0x2008, 0x2004, 0x2000} for stages 0..3, stage_valid = 4'b1111.
- Steady stream, redirect_valid=1, target 0x3003, one cycle → next_pc = 0x3000 that cycle; after the edge stage0 = 0x3000 valid, stages 1–2 invalid, stage 3 = old stage 2 PC, valid.
- stall=1 for 3 cycles with redirect to 0x4000 pulsed in the 2nd stall cycle → stage registers unchanged; next_pc = 0x4000 from the 3rd stall cycle; first advance loads 0x4000 and clears stage_valid[2:1].
- Two redirects during one stall (0x5000 then 0x6000) → 0x6000 is fetched; 0x5000 never reaches stage 0.
- Pending 0x4000 and live redirect 0x7000 on the advance cycle → stage0 = 0x7000, pending cleared, next cycle next_pc = 0x7004.
- Reset pulse mid-stall with pending set → outputs return to reset values immediately; after release, fetch restarts at 0x2000 with no leftover redirect.
- Parameter sweep DEPTH=2/REDIRECT_STAGE=0 and DEPTH=6/REDIRECT_STAGE=4 → squash clears exactly stages 1..REDIRECT_STAGE.

Source files
------------

// File: rtl/pc_pipeline.sv
// pc_pipeline: next-fetch-address generator plus a DEPTH-deep PC/valid
// tracking shift register. It handles a global stall and a control-flow
// redirect that squashes younger stages. A redirect seen during a stall is
// parked as "pending" and applied on the first advance edge.

// One tracked pipeline slot: PC and valid, loaded only on an advance edge.
module pc_stage #(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            adv_i,
    input  logic            kill_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            vld_i,
    output logic [XLEN-1:0] pc_o,
    output logic            vld_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            vld_q, vld_d;

    // Hold unless advancing; a killed slot takes the PC but loses valid.
    always_comb begin
        pc_d  = pc_q;
        vld_d = vld_q;
        if (adv_i) begin
            pc_d  = pc_i;
            vld_d = vld_i & ~kill_i;
        end
    end

    // Slot state register, async reset to the slot's reset PC and invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RST_VAL;
            vld_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            vld_q <= vld_d;
        end
    end

    assign pc_o  = pc_q;
    assign vld_o = vld_q;

endmodule

module pc_pipeline #(
    parameter int              XLEN           = 32,
    parameter int              DEPTH          = 4,
    parameter logic [XLEN-1:0] RESET_PC       = 'h0000_2000,
    parameter int              INCR           = 4,
    parameter int              REDIRECT_STAGE = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_target,
    output logic [XLEN-1:0]         next_pc,
    output logic                    icache_re,
    output logic [DEPTH*XLEN-1:0]   stage_pc,
    output logic [DEPTH-1:0]        stage_valid
);

    localparam logic [XLEN-1:0] INCR_V  = XLEN'(INCR);
    // Stage 0 resets one increment behind so the first sequential fetch is RESET_PC.
    localparam logic [XLEN-1:0] PC0_RST = RESET_PC - INCR_V;

    logic [DEPTH-1:0][XLEN-1:0] pc_q;
    logic [DEPTH-1:0]           vld_q;

    logic                       pend_vld_q, pend_vld_d;
    logic [XLEN-1:0]            pend_tgt_q, pend_tgt_d;

    logic [XLEN-1:0]            redir_tgt;
    logic                       take_redir;
    logic                       advance;

    // Low two bits are ignored: targets are always word aligned.
    assign redir_tgt  = {redirect_target[XLEN-1:2], 2'b00};
    // Redirect consumed by this advance, whether live or parked.
    assign take_redir = redirect_valid | pend_vld_q;
    assign advance    = ~stall;

    // Fetch address priority: live redirect, then pending, then sequential.
    // Deliberately independent of stall so the icache sees the parked target.
    always_comb begin
        if (redirect_valid)   next_pc = redir_tgt;
        else if (pend_vld_q)  next_pc = pend_tgt_q;
        else                  next_pc = pc_q[0] + INCR_V;
    end

    assign icache_re = ~reset;

    // Pending redirect next-state: captured while stalled (last wins), dropped on advance.
    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        if (stall) begin
            if (redirect_valid) begin
                pend_vld_d = 1'b1;
                pend_tgt_d = redir_tgt;
            end
        end else begin
            pend_vld_d = 1'b0;
        end
    end

    // Pending redirect register; reset clears it so no stale redirect survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld_q <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    // Stage array. Stage 0 loads the fetch address; others shift from below.
    // Stages 1..REDIRECT_STAGE hold wrong-path instructions on a redirect and
    // are killed; the redirecting instruction itself lands in REDIRECT_STAGE+1.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            pc_stage #(.XLEN(XLEN), .RST_VAL(PC0_RST)) u_stage (
                .clk    (clk),
                .reset  (reset),
                .adv_i  (advance),
                .kill_i (1'b0),
                .pc_i   (next_pc),
                .vld_i  (1'b1),
                .pc_o   (pc_q[i]),
                .vld_o  (vld_q[i])
            );
        end else begin : g_body
            logic kill;
            assign kill = (i <= REDIRECT_STAGE) && take_redir;
            pc_stage #(.XLEN(XLEN), .RST_VAL('0)) u_stage (
                .clk    (clk),
                .reset  (reset),
                .adv_i  (advance),
                .kill_i (kill),
                .pc_i   (pc_q[i-1]),
                .vld_i  (vld_q[i-1]),
                .pc_o   (pc_q[i]),
                .vld_o  (vld_q[i])
            );
        end
    end

    assign stage_pc    = pc_q;
    assign stage_valid = vld_q;

endmodule

// File: tb/tb_pc_pipeline.sv
module tb_pc_pipeline;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: DEPTH=4, REDIRECT_STAGE=2
    logic         reset = 1'b1, stall = 1'b0, rv = 1'b0;
    logic [31:0]  tgt = '0;
    logic [31:0]  next_pc;
    logic         icache_re;
    logic [127:0] stage_pc;
    logic [3:0]   stage_valid;

    pc_pipeline dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(rv),
        .redirect_target(tgt), .next_pc(next_pc), .icache_re(icache_re),
        .stage_pc(stage_pc), .stage_valid(stage_valid)
    );

    // Sweep DUTs share one stimulus set
    logic         rst2 = 1'b1, stall2 = 1'b0, rv2 = 1'b0;
    logic [31:0]  tgt2 = '0;
    logic [31:0]  npc_a, npc_b;
    logic         re_a, re_b;
    logic [63:0]  sp_a;
    logic [1:0]   v_a;
    logic [191:0] sp_b;
    logic [5:0]   v_b;

    pc_pipeline #(.DEPTH(2), .REDIRECT_STAGE(0)) dut_a (
        .clk(clk), .reset(rst2), .stall(stall2), .redirect_valid(rv2),
        .redirect_target(tgt2), .next_pc(npc_a), .icache_re(re_a),
        .stage_pc(sp_a), .stage_valid(v_a)
    );

    pc_pipeline #(.DEPTH(6), .REDIRECT_STAGE(4)) dut_b (
        .clk(clk), .reset(rst2), .stall(stall2), .redirect_valid(rv2),
        .redirect_target(tgt2), .next_pc(npc_b), .icache_re(re_b),
        .stage_pc(sp_b), .stage_valid(v_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        rst, stl, rv;
        logic [31:0] tgt;
        logic [31:0] npc;
        logic [31:0] s0, s1, s2, s3;
        logic [3:0]  v;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];

    task automatic add(input logic r, input logic s, input logic v_rv, input logic [31:0] t,
                       input logic [31:0] npc, input logic [31:0] s0, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [31:0] s3, input logic [3:0] v);
        vec_t e;
        e.rst = r; e.stl = s; e.rv = v_rv; e.tgt = t; e.npc = npc;
        e.s0 = s0; e.s1 = s1; e.s2 = s2; e.s3 = s3; e.v = v;
        vecs.push_back(e);
    endtask

    initial begin
        // Each row: inputs for the cycle, and expected outputs during it (before its edge).
        //   rst stl rv  tgt           next_pc       s0            s1            s2            s3            valid
        add(1, 0, 0, 32'h0,        32'h2000,     32'h1FFC,     32'h0,        32'h0,        32'h0,        4'b0000);
        add(0, 0, 0, 32'h0,        32'h2000,     32'h1FFC,     32'h0,        32'h0,        32'h0,        4'b0000);
        add(0, 0, 0, 32'h0,        32'h2004,     32'h2000,     32'h1FFC,     32'h0,        32'h0,        4'b0001);
        add(0, 0, 0, 32'h0,        32'h2008,     32'h2004,     32'h2000,     32'h1FFC,     32'h0,        4'b0011);
        add(0, 0, 0, 32'h0,        32'h200C,     32'h2008,     32'h2004,     32'h2000,     32'h1FFC,     4'b0111);
        // full pipe; live redirect with unaligned target
        add(0, 0, 1, 32'h3003,     32'h3000,     32'h200C,     32'h2008,     32'h2004,     32'h2000,     4'b1111);
        // three stall cycles, redirect in the second
        add(0, 1, 0, 32'h0,        32'h3004,     32'h3000,     32'h200C,     32'h2008,     32'h2004,     4'b1001);
        add(0, 1, 1, 32'h4000,     32'h4000,     32'h3000,     32'h200C,     32'h2008,     32'h2004,     4'b1001);
        add(0, 1, 0, 32'h0,        32'h4000,     32'h3000,     32'h200C,     32'h2008,     32'h2004,     4'b1001);
        add(0, 0, 0, 32'h0,        32'h4000,     32'h3000,     32'h200C,     32'h2008,     32'h2004,     4'b1001);
        // two redirects in one stall: last wins
        add(0, 1, 1, 32'h5000,     32'h5000,     32'h4000,     32'h3000,     32'h200C,     32'h2008,     4'b0001);
        add(0, 1, 1, 32'h6000,     32'h6000,     32'h4000,     32'h3000,     32'h200C,     32'h2008,     4'b0001);
        add(0, 1, 0, 32'h0,        32'h6000,     32'h4000,     32'h3000,     32'h200C,     32'h2008,     4'b0001);
        add(0, 0, 0, 32'h0,        32'h6000,     32'h4000,     32'h3000,     32'h200C,     32'h2008,     4'b0001);
        // pending 0x4000 vs live 0x7003 on advance
        add(0, 1, 1, 32'h4000,     32'h4000,     32'h6000,     32'h4000,     32'h3000,     32'h200C,     4'b0001);
        add(0, 0, 1, 32'h7003,     32'h7000,     32'h6000,     32'h4000,     32'h3000,     32'h200C,     4'b0001);
        add(0, 0, 0, 32'h0,        32'h7004,     32'h7000,     32'h6000,     32'h4000,     32'h3000,     4'b0001);
        // park a redirect, then reset mid-stall
        add(0, 1, 1, 32'h8000,     32'h8000,     32'h7004,     32'h7000,     32'h6000,     32'h4000,     4'b0011);
        add(1, 1, 0, 32'h0,        32'h2000,     32'h1FFC,     32'h0,        32'h0,        32'h0,        4'b0000);
        add(0, 0, 0, 32'h0,        32'h2000,     32'h1FFC,     32'h0,        32'h0,        32'h0,        4'b0000);
        // redirect to top of address space, then wrap
        add(0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h2000,   32'h1FFC,     32'h0,        32'h0,        4'b0001);
        add(0, 0, 0, 32'h0,        32'h0000_0000, 32'hFFFF_FFFC, 32'h2000,   32'h1FFC,     32'h0,        4'b0001);
        add(0, 0, 0, 32'h0,        32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFC, 32'h2000,   32'h1FFC,     4'b0011);

        @(posedge clk); #1;
        foreach (vecs[k]) begin
            reset = vecs[k].rst; stall = vecs[k].stl; rv = vecs[k].rv; tgt = vecs[k].tgt;
            if (vecs[k].rst) sb.delete();
            #1;
            // async reset must already be visible, well before the next edge
            if (vecs[k].rst) chk($sformatf("r%0d_async_s0", k), stage_pc[31:0], 32'h1FFC);
            @(negedge clk);
            if (sb.size() > 0) chk($sformatf("r%0d_sb_stage0", k), stage_pc[31:0], sb.pop_front());
            chk($sformatf("r%0d_next_pc", k), next_pc, vecs[k].npc);
            chk($sformatf("r%0d_s0", k), stage_pc[31:0],   vecs[k].s0);
            chk($sformatf("r%0d_s1", k), stage_pc[63:32],  vecs[k].s1);
            chk($sformatf("r%0d_s2", k), stage_pc[95:64],  vecs[k].s2);
            chk($sformatf("r%0d_s3", k), stage_pc[127:96], vecs[k].s3);
            chk($sformatf("r%0d_valid", k), {28'b0, stage_valid}, {28'b0, vecs[k].v});
            chk($sformatf("r%0d_icache_re", k), {31'b0, icache_re}, {31'b0, ~vecs[k].rst});
            if (!vecs[k].rst && !vecs[k].stl) sb.push_back(vecs[k].npc);
            @(posedge clk); #1;
        end
        reset = 1'b0; stall = 1'b0; rv = 1'b0;

        // Parameter sweep: DEPTH=2/RS=0 and DEPTH=6/RS=4
        rst2 = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        chk("b_fill_valid", {26'b0, v_b}, {26'b0, 6'b111111});
        chk("a_fill_s0", sp_a[31:0], 32'h2014);
        chk("b_fill_s4", sp_b[159:128], 32'h2004);
        rv2 = 1'b1; tgt2 = 32'h9002;
        @(negedge clk);
        chk("a_redir_npc", npc_a, 32'h9000);
        chk("b_redir_npc", npc_b, 32'h9000);
        @(posedge clk); #1;
        rv2 = 1'b0;
        chk("a_squash_valid", {30'b0, v_a}, {30'b0, 2'b11});
        chk("a_squash_s0", sp_a[31:0], 32'h9000);
        chk("a_squash_s1", sp_a[63:32], 32'h2014);
        chk("b_squash_valid", {26'b0, v_b}, {26'b0, 6'b100001});
        chk("b_squash_s0", sp_b[31:0], 32'h9000);
        chk("b_squash_s5", sp_b[191:160], 32'h2004);
        @(posedge clk); #1;
        chk("b_after_valid", {26'b0, v_b}, {26'b0, 6'b000011});
        chk("a_after_s0", sp_a[31:0], 32'h9004);
        chk("a_after_valid", {30'b0, v_a}, {30'b0, 2'b11});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
